// File: rtl/miner_pkg.sv
// -----------------------------------------------------------------------------
// miner_pkg
// Shared definitions for the mining pipeline tail logic.
//   NONCE_W  : width of the nonce word carried down the pipeline
//   DIGEST_W : width of the leading digest word compared against the target
//   state_e  : collector FSM states
// -----------------------------------------------------------------------------
package miner_pkg;

   localparam int NONCE_W  = 64;
   localparam int DIGEST_W = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_e;

endpackage : miner_pkg

// File: rtl/hash_cmp.sv
// -----------------------------------------------------------------------------
// hash_cmp
// Unsigned less-than comparator between a digest word and the host target.
// Kept as its own block so a pipeline register can be dropped in later for
// timing (which would add one cycle of hit latency).
// Ports:
//   digest_i : digest word under test
//   target_i : unsigned threshold
//   lt_o     : 1 when digest_i < target_i (strict, unsigned)
// -----------------------------------------------------------------------------
module hash_cmp
   import miner_pkg::*;
(
   input  logic [DIGEST_W-1:0] digest_i,
   input  logic [DIGEST_W-1:0] target_i,
   output logic                lt_o
);

   // A target of zero can never be beaten because nothing is below zero.
   assign lt_o = (digest_i < target_i);

endmodule : hash_cmp

// File: rtl/nonce_collect.sv
// -----------------------------------------------------------------------------
// nonce_collect
// Tail-end result collector of the mining pipeline. Compares every valid
// digest against the host target, raises a one-cycle flush on a hit, latches
// the winning nonce until the host acknowledges, and counts evaluated hashes.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : host pulse, IDLE -> RUN (clears hashCnt)
//   stop      : host pulse, back to IDLE (loses to a hit in RUN)
//   target    : unsigned threshold, held stable while running
//   vldIn     : pipeline-tail valid
//   m04In     : pipeline-tail nonce word
//   hashIn    : leading digest word aligned with vldIn
//   found     : registered one-cycle flush pulse to every stage
//   nonceVld  : nonceOut holds a winning nonce
//   nonceOut  : latched winning nonce
//   ack       : host has read the nonce (HOLD -> RUN)
//   busy      : FSM is in RUN or HOLD
//   hashCnt   : number of valid digests evaluated, wraps
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module nonce_collect
   import miner_pkg::*;
#(
   parameter int CNT_W = 32
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                stop,
   input  logic [DIGEST_W-1:0] target,
   input  logic                vldIn,
   input  logic [NONCE_W-1:0]  m04In,
   input  logic [DIGEST_W-1:0] hashIn,
   output logic                found,
   output logic                nonceVld,
   output logic [NONCE_W-1:0]  nonceOut,
   input  logic                ack,
   output logic                busy,
   output logic [CNT_W-1:0]    hashCnt
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e               state_q, state_d;
   logic                 found_q, found_d;
   logic                 nonce_vld_q, nonce_vld_d;
   logic [NONCE_W-1:0]   nonce_q, nonce_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 lt_s;
   logic                 hit_s;

   hash_cmp u_hash_cmp (
      .digest_i (hashIn),
      .target_i (target),
      .lt_o     (lt_s)
   );

   // Only a valid beat seen while running can be a hit; HOLD ignores the tail.
   assign hit_s = (state_q == RUN) && vldIn && lt_s;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: a hit beats stop in RUN, stop beats ack in HOLD.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (hit_s) begin
               state_d = HOLD;
            end else if (stop) begin
               state_d = IDLE;
            end else begin
               state_d = RUN;
            end
         end
         HOLD: begin
            if (stop) begin
               state_d = IDLE;
            end else if (ack) begin
               state_d = RUN;
            end else begin
               state_d = HOLD;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Next values of the registered outputs.
   always_comb begin
      found_d     = 1'b0;
      nonce_vld_d = nonce_vld_q;
      nonce_d     = nonce_q;
      cnt_d       = cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               cnt_d = CNT_ZERO;
            end else begin
               cnt_d = cnt_q;
            end
         end
         RUN: begin
            if (vldIn) begin
               cnt_d = cnt_q + CNT_ONE;
            end else begin
               cnt_d = cnt_q;
            end
            if (hit_s) begin
               found_d     = 1'b1;
               nonce_vld_d = 1'b1;
               nonce_d     = m04In;
            end else begin
               found_d     = 1'b0;
            end
         end
         HOLD: begin
            // The nonce word itself is kept after release; only the valid drops.
            if (stop || ack) begin
               nonce_vld_d = 1'b0;
            end else begin
               nonce_vld_d = nonce_vld_q;
            end
         end
         default: begin
            nonce_vld_d = 1'b0;
         end
      endcase
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         found_q     <= 1'b0;
         nonce_vld_q <= 1'b0;
         nonce_q     <= {NONCE_W{1'b0}};
         cnt_q       <= CNT_ZERO;
      end else begin
         found_q     <= found_d;
         nonce_vld_q <= nonce_vld_d;
         nonce_q     <= nonce_d;
         cnt_q       <= cnt_d;
      end
   end

   assign found    = found_q;
   assign nonceVld = nonce_vld_q;
   assign nonceOut = nonce_q;
   assign hashCnt  = cnt_q;
   assign busy     = (state_q != IDLE);

endmodule : nonce_collect

// File: tb/tb_nonce_collect.sv
// -----------------------------------------------------------------------------
// tb_nonce_collect
// Self-checking bench for nonce_collect: directed scenarios followed by
// randomized traffic, all compared every cycle against a behavioural model.
// A narrow counter width makes the wrap-around reachable in a few hundred beats.
// -----------------------------------------------------------------------------
module tb_nonce_collect;

   localparam int CW = 8;

   logic           clk = 1'b0;
   logic           rst, start, stop, vldIn, ack;
   logic [63:0]    target, m04In, hashIn;
   logic           found, nonceVld, busy;
   logic [63:0]    nonceOut;
   logic [CW-1:0]  hashCnt;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: mode 0 = stopped, 1 = mining, 2 = waiting for host read.
   int             m_mode;
   bit             m_found, m_nv;
   logic [63:0]    m_nonce;
   int unsigned    m_hashes;

   always #5 clk = ~clk;

   nonce_collect #(.CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .target(target),
      .vldIn(vldIn), .m04In(m04In), .hashIn(hashIn), .found(found),
      .nonceVld(nonceVld), .nonceOut(nonceOut), .ack(ack), .busy(busy),
      .hashCnt(hashCnt)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Apply the behavioural rules for one clock edge using the current inputs.
   task automatic model_edge();
      bit hit;
      if (rst) begin
         m_mode = 0; m_found = 0; m_nv = 0; m_nonce = '0; m_hashes = 0;
      end else begin
         m_found = 0;
         if (m_mode == 0) begin
            if (start) begin m_mode = 1; m_hashes = 0; end
         end else if (m_mode == 1) begin
            hit = vldIn && (hashIn < target);
            if (vldIn) m_hashes = m_hashes + 1;
            if (hit) begin
               m_found = 1; m_nv = 1; m_nonce = m04In; m_mode = 2;
            end else if (stop) begin
               m_mode = 0;
            end
         end else begin
            if (stop) begin m_mode = 0; m_nv = 0; end
            else if (ack) begin m_mode = 1; m_nv = 0; end
         end
      end
   endtask

   task automatic step();
      logic [CW-1:0] exp_cnt;
      model_edge();
      @(posedge clk);
      #1;
      exp_cnt = CW'(m_hashes % (1 << CW));
      check_val("found",    {63'd0, found},    {63'd0, m_found});
      check_val("nonceVld", {63'd0, nonceVld}, {63'd0, m_nv});
      check_val("nonceOut", nonceOut, m_nonce);
      check_val("busy",     {63'd0, busy},     {63'd0, (m_mode != 0)});
      check_val("hashCnt",  {{(64-CW){1'b0}}, hashCnt}, {{(64-CW){1'b0}}, exp_cnt});
   endtask

   task automatic clear_in();
      rst = 1'b0; start = 1'b0; stop = 1'b0; ack = 1'b0; vldIn = 1'b0;
      m04In = 64'd0; hashIn = 64'd0;
   endtask

   task automatic beat(input logic [63:0] h, input logic [63:0] n);
      vldIn = 1'b1; hashIn = h; m04In = n;
      step();
      vldIn = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1; step(); start = 1'b0;
   endtask

   initial begin
      logic [63:0] tgt;
      clear_in();
      target = 64'h0000_0001_0000_0000;
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      check_val("rst_busy", {63'd0, busy}, 64'd0);
      check_val("rst_cnt",  {{(64-CW){1'b0}}, hashCnt}, 64'd0);

      // Misses only.
      pulse_start();
      for (int i = 0; i < 5; i++) beat(64'hFFFF_FFFF_FFFF_FFFF, 64'(i));
      check_val("miss_cnt", {{(64-CW){1'b0}}, hashCnt}, 64'd5);
      check_val("miss_found", {63'd0, found}, 64'd0);

      // First hit and HOLD behaviour.
      beat(64'h0000_0000_FFFF_FFFF, 64'hDEAD_BEEF_0000_0042);
      check_val("hit_found", {63'd0, found}, 64'd1);
      check_val("hit_nonce", nonceOut, 64'hDEAD_BEEF_0000_0042);
      beat(64'd0, 64'h1111_2222_3333_4444);
      check_val("pulse_len", {63'd0, found}, 64'd0);
      beat(64'd0, 64'h5555_6666_7777_8888);
      check_val("hold_nonce", nonceOut, 64'hDEAD_BEEF_0000_0042);
      check_val("hold_cnt", {{(64-CW){1'b0}}, hashCnt}, 64'd6);
      ack = 1'b1; step(); ack = 1'b0;

      // Boundary around target.
      beat(target, 64'hAAAA);
      check_val("eq_nohit", {63'd0, found}, 64'd0);
      beat(target - 64'd1, 64'hBBBB);
      check_val("lt_hit", {63'd0, found}, 64'd1);
      stop = 1'b1; step(); stop = 1'b0;

      // Zero target never hits.
      target = 64'd0;
      pulse_start();
      for (int i = 0; i < 3; i++) begin
         beat(64'd0, 64'hC0DE);
         check_val("zero_tgt", {63'd0, found}, 64'd0);
      end
      stop = 1'b1; step(); stop = 1'b0;

      // Hit with stop, then ack with stop.
      target = 64'h0000_0001_0000_0000;
      pulse_start();
      stop = 1'b1; beat(64'd5, 64'h1234); stop = 1'b0;
      check_val("hitstop_nv", {63'd0, nonceVld}, 64'd1);
      ack = 1'b1; stop = 1'b1; step(); ack = 1'b0; stop = 1'b0;
      check_val("ackstop_busy", {63'd0, busy}, 64'd0);

      // Earliest resume after ack.
      pulse_start();
      beat(64'd7, 64'hFACE_0001);
      ack = 1'b1; step(); ack = 1'b0;
      beat(64'd9, 64'hFACE_0002);
      check_val("resume_found", {63'd0, found}, 64'd1);
      check_val("resume_nonce", nonceOut, 64'hFACE_0002);

      // Reset during the found pulse.
      ack = 1'b1; step(); ack = 1'b0;
      beat(64'd3, 64'hFACE_0003);
      rst = 1'b1; vldIn = 1'b1; hashIn = 64'd1; step(); clear_in();
      check_val("rst_found", {63'd0, found}, 64'd0);
      check_val("rst_nonce", nonceOut, 64'd0);

      // Counter wrap at 2^CW.
      pulse_start();
      for (int i = 0; i < (1 << CW); i++) beat(64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
      check_val("wrap_cnt", {{(64-CW){1'b0}}, hashCnt}, 64'd0);
      stop = 1'b1; step(); stop = 1'b0;

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         if (m_mode == 0 && ($urandom % 4) == 0) begin
            case ($urandom % 3)
               0: tgt = 64'd0;
               1: tgt = 64'($urandom % 64);
               default: tgt = {$urandom, $urandom};
            endcase
            target = tgt;
         end
         rst   = (($urandom % 500) == 0);
         start = (($urandom % 20) == 0);
         stop  = (($urandom % 40) == 0);
         ack   = (($urandom % 8) == 0);
         vldIn = $urandom % 2;
         m04In = {$urandom, $urandom};
         if (($urandom % 8) == 0 && target != 64'd0) hashIn = {$urandom, $urandom} % target;
         else if (($urandom % 8) == 0) hashIn = target;
         else hashIn = {$urandom, $urandom};
         step();
      end
      clear_in();
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_nonce_collect
